key_schedule_ctrl: RTL and testbench



---
 rtl/key_schedule_ctrl.sv | 165 ++++++++++++++++
 tb/tb_key_schedule_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl.sv
// AES-128 key expansion sequencer: loads a cipher key and hands out round keys 0..NR
// one at a time over valid/ready, time-sharing one external SubWord unit.

module rot_word (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);
  assign word_out = {word_in[23:0], word_in[31:24]};
endmodule

module key_schedule_ctrl #(
  parameter int unsigned NR        = 10,
  parameter logic [7:0]  RCON_INIT = 8'h01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] cipherKey,
  output logic [31:0]  subIn,
  input  logic [31:0]  subOut,
  output logic [127:0] roundKey,
  output logic [3:0]   roundIdx,
  output logic         keyValid,
  input  logic         keyReady,
  output logic         busy,
  output logic         done
);

  // Only AES-128 is supported; an out-of-range NR falls back to 10.
  localparam logic [3:0] LAST_IDX = (NR >= 32'd1 && NR <= 32'd10) ? 4'(NR) : 4'd10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    SUB     = 2'd2,
    XOR     = 2'd3
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [7:0]   rcon;
  logic [7:0]   rcon_next;
  logic [31:0]  temp;
  logic [31:0]  temp_next;
  logic [127:0] key_next;
  logic [3:0]   idx_next;
  logic [31:0]  sub_next;
  logic         valid_next;
  logic         busy_next;
  logic         done_next;
  logic [31:0]  rot_w3;
  logic         handshake;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    logic [7:0] r;
    r = {b[6:0], 1'b0};
    if (b[7]) begin
      r = r ^ 8'h1b;
    end else begin
      r = r;
    end
    return r;
  endfunction

  // Chained word update: each new word depends on the freshly computed previous word.
  function automatic logic [127:0] next_round_key(input logic [127:0] k, input logic [31:0] t);
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  rot_word u_rot_word (
    .word_in  (roundKey[31:0]),
    .word_out (rot_w3)
  );

  assign handshake = keyValid && keyReady;

  // Next-state and next-register values for the sequencer.
  always_comb begin
    state_next = state;
    key_next   = roundKey;
    idx_next   = roundIdx;
    rcon_next  = rcon;
    temp_next  = temp;
    sub_next   = subIn;
    valid_next = keyValid;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = PRESENT;
          key_next   = cipherKey;
          idx_next   = 4'd0;
          rcon_next  = RCON_INIT;
          valid_next = 1'b1;
        end else begin
          valid_next = 1'b0;
        end
      end
      PRESENT: begin
        if (handshake) begin
          valid_next = 1'b0;
          if (roundIdx >= LAST_IDX) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = SUB;
            sub_next   = rot_w3;
          end
        end else begin
          valid_next = 1'b1;
        end
      end
      SUB: begin
        temp_next  = subOut ^ {rcon, 24'h000000};
        state_next = XOR;
      end
      XOR: begin
        key_next   = next_round_key(roundKey, temp);
        idx_next   = roundIdx + 4'd1;
        rcon_next  = xtime(rcon);
        valid_next = 1'b1;
        state_next = PRESENT;
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // Sequencer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      roundKey <= 128'h0;
      roundIdx <= 4'd0;
      keyValid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      subIn    <= 32'h0;
      rcon     <= RCON_INIT;
      temp     <= 32'h0;
    end else begin
      state    <= state_next;
      roundKey <= key_next;
      roundIdx <= idx_next;
      keyValid <= valid_next;
      busy     <= busy_next;
      done     <= done_next;
      subIn    <= sub_next;
      rcon     <= rcon_next;
      temp     <= temp_next;
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl: FIPS-197 word-loop model plus an
// arithmetic S-box drive the external SubWord port and the expected round keys.

module tb_key_schedule_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] JUNK_KEY = 128'hdeadbeef0123456789abcdeffedcba98;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] cipherKey;
  logic [31:0]  subIn;
  logic [31:0]  subOut;
  logic [127:0] roundKey;
  logic [3:0]   roundIdx;
  logic         keyValid;
  logic         keyReady;
  logic         busy;
  logic         done;

  logic [7:0]   sbox [0:255];
  logic [7:0]   rcon_tab [0:10];
  logic [127:0] model_keys [0:10];
  int           n_checks;
  int           n_pass;
  int           dc;

  key_schedule_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cipherKey (cipherKey),
    .subIn     (subIn),
    .subOut    (subOut),
    .roundKey  (roundKey),
    .roundIdx  (roundIdx),
    .keyValid  (keyValid),
    .keyReady  (keyReady),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign subOut = {sbox[subIn[31:24]], sbox[subIn[23:16]], sbox[subIn[15:8]], sbox[subIn[7:0]]};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Textbook FIPS-197 word recurrence over w[0..43].
  task automatic build_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = subword({t[23:0], t[31:24]}) ^ {rcon_tab[i/4], 24'h000000};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_key"}, roundKey, 128'h0);
    chk({tag, "_idx"}, roundIdx, 4'd0);
    chk({tag, "_valid"}, keyValid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_subin"}, subIn, 32'h0);
  endtask

  // Compare process: every presented key must be the model key for its index.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (roundIdx > 4'd10) chk("idx_range", roundIdx, 4'd10);
        else if (keyValid) chk("model_key", roundKey, model_keys[roundIdx]);
      end
    end
  end

  // Runs one schedule whose start the caller has already raised.
  // mode 0: FIPS literals; 1: backpressure + ignored start; 2: reset in XOR;
  // 3: junk start on final handshake then back-to-back start; 4: plain.
  task automatic run_sched(input int mode, output int done_cyc);
    logic [127:0] prev_key;
    logic [31:0]  held;
    int seen_idx, stall_cnt, rel, inj, rst_at;
    done_cyc = 0; seen_idx = -1; stall_cnt = 0; rel = 0; inj = 0; rst_at = 0;
    prev_key = 128'h0; held = 32'h0;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      @(negedge clk);
      if (inj > 0) inj--;
      else start = 1'b0;
      if (cyc == 1) begin
        chk("round0_valid", keyValid, 1'b1);
        chk("round0_idx", roundIdx, 4'd0);
        chk("round0_key", roundKey, cipherKey);
        chk("round0_busy", busy, 1'b1);
      end
      if (mode == 0 && cyc == 2) begin
        chk("first_subin", subIn, 32'hcf4f3c09);
        chk("first_subout", subOut, 32'h8a84eb01);
      end
      if (mode == 1 && stall_cnt > 0 && stall_cnt <= 5) begin
        chk("stall_valid", keyValid, 1'b1);
        chk("stall_idx", roundIdx, 4'd3);
        chk("stall_subin", subIn, held);
        if (stall_cnt == 5) begin
          keyReady = 1'b1;
          rel = cyc;
        end
        stall_cnt++;
      end
      if (rel > 0 && (cyc == rel + 1 || cyc == rel + 2)) chk("release_gap", keyValid, 1'b0);
      if (rel > 0 && cyc == rel + 3) begin
        chk("release_valid", keyValid, 1'b1);
        chk("release_idx", roundIdx, 4'd4);
      end
      if (mode == 2 && rst_at > 0) begin
        if (cyc == rst_at + 1) begin
          check_reset("mid_rst");
          rst = 1'b0;
        end else begin
          chk("no_done_after_rst", done, 1'b0);
          chk("idle_after_rst", keyValid, 1'b0);
        end
        if (cyc == rst_at + 12) break;
      end
      if (mode == 2 && rst_at == 0 && seen_idx == 5 && !keyValid && busy && subIn == model_keys[5][23:0] * 0 + {model_keys[5][23:0], model_keys[5][31:24]} && cyc > 17) begin
        rst = 1'b1;
        rst_at = cyc;
      end
      if (keyValid && int'(roundIdx) != seen_idx) begin
        if (roundIdx != 4'd0)
          chk("rcon_byte", roundKey[127:96] ^ prev_key[127:96] ^ subOut, {rcon_tab[roundIdx], 24'h000000});
        if (mode == 0 && roundIdx == 4'd1) chk("fips_rk1", roundKey, 128'ha0fafe1788542cb123a339392a6c7605);
        if (mode == 0 && roundIdx == 4'd10) chk("fips_rk10", roundKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        if (mode == 1 && roundIdx == 4'd3) begin
          keyReady = 1'b0;
          held = subIn;
          stall_cnt = 1;
        end
        if (mode == 1 && roundIdx == 4'd5) begin
          start = 1'b1;
          cipherKey = ALT_KEY;
          inj = 2;
        end
        if (mode == 3 && roundIdx == 4'd10) begin
          start = 1'b1;
          cipherKey = JUNK_KEY;
        end
        seen_idx = int'(roundIdx);
        prev_key = roundKey;
      end
      if (done && done_cyc == 0) begin
        done_cyc = cyc;
        if (mode == 3) begin
          cipherKey = ALT_KEY;
          build_model(ALT_KEY);
          start = 1'b1;
        end
        break;
      end
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; keyReady = 1'b1; cipherKey = 128'h0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] s;
      logic [7:0] r;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ 8'h63; r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox[x] = s;
    end
    rcon_tab = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    build_model(FIPS_KEY);
    chk("model_subword", subword(32'hcf4f3c09), 32'h8a84eb01);
    chk("model_rk1", model_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_rk10", model_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    repeat (3) @(negedge clk);
    check_reset("reset");
    start = 1'b1; cipherKey = FIPS_KEY;
    @(negedge clk);
    chk("start_under_rst_valid", keyValid, 1'b0);
    chk("start_under_rst_busy", busy, 1'b0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    cipherKey = FIPS_KEY; start = 1'b1;
    run_sched(0, dc);
    chk("done_cycle_basic", dc, 32);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("idle_busy", busy, 1'b0);

    cipherKey = FIPS_KEY; start = 1'b1;
    run_sched(1, dc);
    chk("done_cycle_stall", dc, 37);
    @(negedge clk);

    cipherKey = FIPS_KEY; start = 1'b1;
    run_sched(2, dc);
    chk("no_done_mid_rst", dc, 0);
    @(negedge clk);

    cipherKey = FIPS_KEY; start = 1'b1;
    run_sched(3, dc);
    chk("done_cycle_fresh", dc, 32);
    run_sched(4, dc);
    chk("done_cycle_b2b", dc, 32);
    @(negedge clk);
    chk("final_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, %0d of %0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
